rect_buffer_writer: RTL and testbench
=====================================

Name: rect_buffer_writer

Overview:
Fills the 4-bank rectangle buffer from an incoming camera pixel stream. It sits upstream of the buffer's write port, and the remap reader consumes the buffer through the read port. Pixels are interleaved across banks by (y parity, x parity), so the reader can fetch any 2x2 bilinear neighbourhood in one cycle. The buffer acts as a row ring, with flow control against the reader's row-release pointer.

Parameters:
IMG_WIDTH, 1024, pixels per row; even, at least 4
IMG_HEIGHT, 1024, rows per frame; even
BUF_ROWS, 64, rows held in ring; even power of two; (BUF_ROWS/2)*(IMG_WIDTH/2) must not exceed 32768
ROW_W, 11, width of row counters; must satisfy 2^ROW_W > IMG_HEIGHT

Ports:
clk  in  1  single clock
reset_n  in  1  synchronous, active-low reset
in_data  in  32  two pixels; [15:0] is the even-x pixel, [31:16] is the odd-x pixel
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid && in_ready
in_sop  in  1  first beat of frame
in_eop  in  1  last beat of frame
rows_freed  in  ROW_W  from reader: lowest row index still needed in the current frame
write_address  out  60  four 15-bit bank addresses; bank b uses [15b+14:15b]
write_writedata  out  64  four 16-bit lanes; bank b uses [16b+15:16b]
write_write  out  4  per-bank write enable
rows_written  out  ROW_W  count of rows of the current frame fully committed
frame_done  out  1  one-cycle pulse after the last row is committed
err_sync  out  1  one-cycle pulse on a framing error

Behaviour:
- Reset (reset_n=0 at posedge): state IDLE, x=y=0, and every output is 0 (in_ready=0, write_write=0, rows_written=0, frame_done=0, err_sync=0). Reset mid-frame discards the frame with no further writes.
- States:
  - IDLE: in_ready=1. Beats without in_sop are dropped silently. An accepted beat with in_sop is written as x=0,y=0, then go to RUN.
  - RUN: in_ready = (y < rows_freed + BUF_ROWS). Use ROW_W+1-bit compare, no wrap.
  - DONE: one cycle with frame_done=1 and in_ready=0, then go to IDLE.
- Bank mapping for the beat at (x even, y):
  - Pixel pair goes to banks {y[0],0} and {y[0],1}.
  - write_write = 4'b0011 when y is even, 4'b1100 when y is odd.
  - Both active lanes use addr = ((y>>1) mod (BUF_ROWS/2))*(IMG_WIDTH/2) + (x>>1).
  - Inactive lanes: address and data are 0.
- Latency: outputs are registered. The write strobe is presented exactly 1 cycle after the accepting edge. write_write is 0 in any cycle without a write.
- Counters:
  - x += 2 per accepted beat.
  - At x=IMG_WIDTH-2, x wraps to 0 and y += 1.
  - rows_written increments 1 cycle after the row's last write strobe, giving the reader a committed-row guarantee.
- Frame end: the beat at x=IMG_WIDTH-2, y=IMG_HEIGHT-1 completes the frame. After its rows_written increment, go to DONE. rows_written holds IMG_HEIGHT until the next accepted in_sop resets it to 0.
- Framing errors (err_sync pulses 1 cycle after the offending beat is accepted):
  - in_sop during RUN: the beat is treated as a new frame's x=0,y=0; counters and rows_written reset.
  - in_eop before the final beat: the beat is written, then go to IDLE with no frame_done.
  - Final beat without in_eop: the frame completes normally anyway.
- Simultaneous events: the rows_written increment and a new accepted beat in the same cycle are independent. rows_freed is sampled each cycle, with no latching.

Decomposition:
- Package rect_buffer_pkg:
  - BANK_ADDR_W=15, PIX_W=16, NUM_BANKS=4.
  - Bank-index function bank_of(x0,y0).
  - Bank-address function shared with the remap reader.
- One sub-module, rect_buffer_addr_gen: x/y counters plus bank address and enable generation. It is reusable by the reader.

Test Plan:
All cases use IMG_WIDTH=8, IMG_HEIGHT=4, BUF_ROWS=4.
- Reset, then a full frame (16 beats, sop on first, eop on last), rows_freed=0:
  - Writes proceed for rows 0-3 once the flow-control check passes; the row-0 beat at x=2 gives write_write=0011 with addr 1 on lanes 0/1.
  - rows_written steps 1..4, then frame_done pulses once.
- Beat (x=2,y=3) with pix 0xAAAA/0xBBBB:
  - write_write=1100; write_address[44:30]=[59:45]=5.
  - write_writedata[47:32]=0xAAAA, [63:48]=0xBBBB.
- Back-pressure, BUF_ROWS=2, rows_freed held 0:
  - in_ready drops at y=2, x=0.
  - Raise rows_freed to 1: in_ready=1 next cycle, and the row-2 write goes to addr (1 mod 1)*4+0=0 in banks 0/1.
- in_sop mid-frame at y=1,x=4:
  - err_sync pulses; that beat is written at addr 0, banks 0/1; rows_written=0.
- Early in_eop at y=2,x=6:
  - Beat written; err_sync pulses; no frame_done; state IDLE (non-sop beats dropped).
- reset_n=0 mid-row:
  - All outputs 0 the next cycle; no write_write activity until a new sop is accepted.

Source files
------------

// File: rtl/rect_buffer_pkg.sv
// Shared definitions for the 4-bank rectangle buffer: bank geometry, writer
// states and the (x, y) -> bank / bank-address mapping used by writer and reader.
package rect_buffer_pkg;

  localparam int unsigned BANK_ADDR_W = 15;
  localparam int unsigned PIX_W       = 16;
  localparam int unsigned NUM_BANKS   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } wr_state_t;

  // Bank holding pixel (x0, y0) parities: {y parity, x parity}.
  function automatic logic [1:0] bank_of(input logic x0, input logic y0);
    return {y0, x0};
  endfunction

  // Address of pixel (x, y) inside its bank; ring of BUF_ROWS/2 row pairs.
  function automatic logic [BANK_ADDR_W-1:0] bank_addr(input int unsigned x,
                                                       input int unsigned y,
                                                       input int unsigned buf_rows,
                                                       input int unsigned img_width);
    int unsigned a;
    a = ((y >> 1) % (buf_rows / 2)) * (img_width / 2) + (x >> 1);
    return a[BANK_ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/rect_buffer_addr_gen.sv
// Raster x/y position tracking for two-pixel beats, plus the bank enables and
// bank address of the beat currently presented.
module rect_buffer_addr_gen
  import rect_buffer_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 1024,
  parameter int unsigned IMG_HEIGHT = 1024,
  parameter int unsigned BUF_ROWS   = 64,
  parameter int unsigned ROW_W      = 11
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   step,
  output logic [ROW_W-1:0]       y_next,
  output logic                   row_end,
  output logic                   frame_end,
  output logic [NUM_BANKS-1:0]   bank_en,
  output logic [BANK_ADDR_W-1:0] addr
);

  localparam int unsigned XW = $clog2(IMG_WIDTH);

  logic [XW-1:0]    x;
  logic [XW-1:0]    x_pos;
  logic [XW-1:0]    x_nxt;
  logic [ROW_W-1:0] y;
  logic [ROW_W-1:0] y_pos;

  // A start beat is placed at the origin regardless of the running position.
  always_comb begin
    x_pos     = start ? '0 : x;
    y_pos     = start ? '0 : y;
    row_end   = (32'(x_pos) == IMG_WIDTH - 2);
    frame_end = row_end && (32'(y_pos) == IMG_HEIGHT - 1);
    x_nxt     = x;
    y_next    = y;
    if (step) begin
      x_nxt  = row_end ? '0 : x_pos + XW'(2);
      y_next = row_end ? y_pos + ROW_W'(1) : y_pos;
    end
    bank_en = '0;
    bank_en[bank_of(1'b0, y_pos[0])] = 1'b1;
    bank_en[bank_of(1'b1, y_pos[0])] = 1'b1;
    addr = bank_addr(32'(x_pos), 32'(y_pos), BUF_ROWS, IMG_WIDTH);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= x_nxt;
      y <= y_next;
    end
  end

endmodule

// File: rtl/rect_buffer_writer.sv
// Camera-stream writer for the 4-bank rectangle buffer: registered bank writes,
// row-commit counting and ring flow control against the reader's release pointer.
module rect_buffer_writer
  import rect_buffer_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 1024,
  parameter int unsigned IMG_HEIGHT = 1024,
  parameter int unsigned BUF_ROWS   = 64,
  parameter int unsigned ROW_W      = 11
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [31:0]                        in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_sop,
  input  logic                               in_eop,
  input  logic [ROW_W-1:0]                   rows_freed,
  output logic [NUM_BANKS*BANK_ADDR_W-1:0]   write_address,
  output logic [NUM_BANKS*PIX_W-1:0]         write_writedata,
  output logic [NUM_BANKS-1:0]               write_write,
  output logic [ROW_W-1:0]                   rows_written,
  output logic                               frame_done,
  output logic                               err_sync
);

  wr_state_t                      state;
  logic                           accept;
  logic                           write_beat;
  logic                           row_end;
  logic                           frame_end;
  logic                           row_pending;
  logic                           ready_run;
  logic [ROW_W-1:0]               y_next;
  logic [NUM_BANKS-1:0]           bank_en;
  logic [BANK_ADDR_W-1:0]         addr;
  logic [NUM_BANKS*BANK_ADDR_W-1:0] addr_lanes;
  logic [NUM_BANKS*PIX_W-1:0]     data_lanes;

  assign accept     = in_valid && in_ready;
  assign write_beat = accept && (in_sop || state == ST_RUN);
  // Ready is registered, so it is judged on the row the next beat would land in.
  assign ready_run  = {1'b0, y_next} < ({1'b0, rows_freed} + (ROW_W+1)'(BUF_ROWS));

  rect_buffer_addr_gen #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT),
    .BUF_ROWS  (BUF_ROWS),
    .ROW_W     (ROW_W)
  ) u_addr_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (in_sop),
    .step     (write_beat),
    .y_next   (y_next),
    .row_end  (row_end),
    .frame_end(frame_end),
    .bank_en  (bank_en),
    .addr     (addr)
  );

  always_comb begin
    addr_lanes = '0;
    data_lanes = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (bank_en[b]) begin
        addr_lanes[BANK_ADDR_W*b +: BANK_ADDR_W] = addr;
        data_lanes[PIX_W*b +: PIX_W] = b[0] ? in_data[31:16] : in_data[15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      in_ready        <= 1'b0;
      write_write     <= '0;
      write_address   <= '0;
      write_writedata <= '0;
      rows_written    <= '0;
      frame_done      <= 1'b0;
      err_sync        <= 1'b0;
      row_pending     <= 1'b0;
    end else begin
      write_write     <= write_beat ? bank_en : '0;
      write_address   <= write_beat ? addr_lanes : '0;
      write_writedata <= write_beat ? data_lanes : '0;
      row_pending     <= write_beat && row_end;
      frame_done      <= 1'b0;
      err_sync        <= write_beat && ((state == ST_RUN && in_sop) || (in_eop && !frame_end));
      // A restart wins over a commit still in flight from the abandoned frame.
      if (write_beat && in_sop)
        rows_written <= '0;
      else if (row_pending)
        rows_written <= rows_written + ROW_W'(1);
      case (state)
        ST_IDLE, ST_RUN: begin
          if (write_beat) begin
            if (frame_end) begin
              state    <= ST_FLUSH;
              in_ready <= 1'b0;
            end else if (in_eop) begin
              state    <= ST_IDLE;
              in_ready <= 1'b1;
            end else begin
              state    <= ST_RUN;
              in_ready <= ready_run;
            end
          end else begin
            in_ready <= (state == ST_IDLE) ? 1'b1 : ready_run;
          end
        end
        ST_FLUSH: begin
          state      <= ST_DONE;
          frame_done <= 1'b1;
          in_ready   <= 1'b0;
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rect_buffer_writer.sv
// Bench for rect_buffer_writer: two instances (4-row and 2-row rings) against a
// beat-index reference model, plus directed scenarios with literal expectations.
module tb_rect_buffer_writer;

  localparam int unsigned W   = 8;
  localparam int unsigned H   = 4;
  localparam int unsigned RW  = 4;
  localparam int unsigned BR0 = 4;
  localparam int unsigned BR1 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          in_valid [2];
  logic          in_sop   [2];
  logic          in_eop   [2];
  logic          in_ready [2];
  logic          frame_done [2];
  logic          err_sync [2];
  logic [31:0]   in_data  [2];
  logic [RW-1:0] rows_freed [2];
  logic [RW-1:0] rows_written [2];
  logic [59:0]   wa [2];
  logic [63:0]   wd [2];
  logic [3:0]    ww [2];

  rect_buffer_writer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .BUF_ROWS(BR0), .ROW_W(RW)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .in_sop(in_sop[0]), .in_eop(in_eop[0]),
    .rows_freed(rows_freed[0]), .write_address(wa[0]), .write_writedata(wd[0]),
    .write_write(ww[0]), .rows_written(rows_written[0]), .frame_done(frame_done[0]),
    .err_sync(err_sync[0]));

  rect_buffer_writer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .BUF_ROWS(BR1), .ROW_W(RW)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .in_sop(in_sop[1]), .in_eop(in_eop[1]),
    .rows_freed(rows_freed[1]), .write_address(wa[1]), .write_writedata(wd[1]),
    .write_write(ww[1]), .rows_written(rows_written[1]), .frame_done(frame_done[1]),
    .err_sync(err_sync[1]));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h", name, i, act, exp);
    end
  endtask

  // Reference model: frame progress is a beat index k; position and bank
  // address follow from raster arithmetic.
  int          mode [2];   // 0 idle, 1 in frame, 2 last strobe, 3 done pulse
  int          k    [2];
  int          rw   [2];
  bit          pend [2];
  logic        e_ready [2];
  logic [3:0]  e_ww [2];
  logic [59:0] e_addr [2];
  logic [63:0] e_data [2];
  logic        e_fd [2];
  logic        e_err [2];
  bit          armed = 1'b0;
  int          fd_count [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin : mdl
      int x, y, a, b, bufr;
      bit acc;
      bufr = (i == 0) ? BR0 : BR1;
      if (!reset_n) begin
        mode[i] = 0; k[i] = 0; rw[i] = 0; pend[i] = 1'b0;
        e_ready[i] = 1'b0; e_ww[i] = '0; e_addr[i] = '0; e_data[i] = '0;
        e_fd[i] = 1'b0; e_err[i] = 1'b0;
        armed = 1'b1;
      end else begin
        acc = in_valid[i] && e_ready[i];
        e_ww[i] = '0; e_addr[i] = '0; e_data[i] = '0; e_fd[i] = 1'b0; e_err[i] = 1'b0;
        if (pend[i]) rw[i]++;
        pend[i] = 1'b0;
        if (acc && (in_sop[i] || mode[i] == 1)) begin
          if (in_sop[i]) begin
            if (mode[i] == 1) e_err[i] = 1'b1;
            k[i] = 0;
            rw[i] = 0;
          end
          x = (k[i] % (W / 2)) * 2;
          y = k[i] / (W / 2);
          a = ((y / 2) % (bufr / 2)) * (W / 2) + x / 2;
          for (int p = 0; p < 2; p++) begin
            b = (y % 2) * 2 + p;
            e_ww[i][b] = 1'b1;
            e_addr[i][15*b +: 15] = 15'(a);
            e_data[i][16*b +: 16] = (p == 1) ? in_data[i][31:16] : in_data[i][15:0];
          end
          if (x == W - 2) pend[i] = 1'b1;
          k[i]++;
          if (k[i] == W * H / 2) mode[i] = 2;
          else if (in_eop[i]) begin
            e_err[i] = 1'b1;
            mode[i] = 0;
          end else mode[i] = 1;
        end else if (mode[i] == 2) begin
          mode[i] = 3;
          e_fd[i] = 1'b1;
        end else if (mode[i] == 3) begin
          mode[i] = 0;
        end
        if (mode[i] == 0) e_ready[i] = 1'b1;
        else if (mode[i] == 1) e_ready[i] = (k[i] / (W / 2)) < (int'(rows_freed[i]) + bufr);
        else e_ready[i] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        chk("in_ready", i, 64'(in_ready[i]), 64'(e_ready[i]));
        chk("write_write", i, 64'(ww[i]), 64'(e_ww[i]));
        chk("write_address", i, 64'(wa[i]), 64'(e_addr[i]));
        chk("write_writedata", i, wd[i], e_data[i]);
        chk("rows_written", i, 64'(rows_written[i]), 64'(rw[i]));
        chk("frame_done", i, 64'(frame_done[i]), 64'(e_fd[i]));
        chk("err_sync", i, 64'(err_sync[i]), 64'(e_err[i]));
        if (frame_done[i] === 1'b1) fd_count[i]++;
      end
    end
  end

  // Present one beat and hold it until accepted; returns in the strobe cycle.
  task automatic send(input int i, input logic [31:0] d, input logic s, input logic e);
    int n;
    @(negedge clk);
    in_valid[i] = 1'b1; in_data[i] = d; in_sop[i] = s; in_eop[i] = e;
    n = 0;
    while (in_ready[i] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("handshake", i, 64'(in_ready[i]), 64'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid[i] = 1'b0; in_sop[i] = 1'b0; in_eop[i] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; in_sop[i] = 1'b0; in_eop[i] = 1'b0;
      in_data[i] = '0; rows_freed[i] = '0; fd_count[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("reset_ready", 0, 64'(in_ready[0]), 0);
    chk("reset_we", 0, 64'(ww[0]), 0);
    chk("reset_rows", 1, 64'(rows_written[1]), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 0, 64'(in_ready[0]), 1);

    // Full frame on the 4-row ring
    for (int n = 0; n < 16; n++) begin
      send(0, (n == 13) ? 32'hBBBB_AAAA : $urandom, n == 0, n == 15);
      if (n == 1) begin
        chk("row0_x2_we", 0, 64'(ww[0]), 64'h3);
        chk("row0_x2_addr", 0, 64'(wa[0][29:0]), 64'({15'd1, 15'd1}));
      end
      if (n == 13) begin
        chk("y3_x2_we", 0, 64'(ww[0]), 64'hC);
        chk("y3_x2_addr", 0, 64'(wa[0][59:30]), 64'({15'd5, 15'd5}));
        chk("y3_x2_data", 0, 64'(wd[0][63:32]), 64'h0000_0000_BBBB_AAAA);
      end
      if (n % 4 == 0) chk("rows_step", 0, 64'(rows_written[0]), 64'(n / 4));
    end
    @(negedge clk);
    chk("frame_rows", 0, 64'(rows_written[0]), 4);
    chk("frame_done_pulse", 0, 64'(frame_done[0]), 1);
    chk("done_ready", 0, 64'(in_ready[0]), 0);
    @(negedge clk);
    chk("frame_done_end", 0, 64'(frame_done[0]), 0);
    chk("back_idle_ready", 0, 64'(in_ready[0]), 1);
    chk("frame_done_count", 0, 64'(fd_count[0]), 1);

    // Back-pressure on the 2-row ring
    for (int n = 0; n < 8; n++) send(1, $urandom, n == 0, 1'b0);
    chk("bp_ready_drop", 1, 64'(in_ready[1]), 0);
    repeat (2) @(negedge clk);
    chk("bp_ready_hold", 1, 64'(in_ready[1]), 0);
    rows_freed[1] = 4'd1;
    @(negedge clk);
    chk("bp_ready_release", 1, 64'(in_ready[1]), 1);
    send(1, 32'h2222_1111, 1'b0, 1'b0);
    chk("bp_row2_we", 1, 64'(ww[1]), 64'h3);
    chk("bp_row2_addr", 1, 64'(wa[1]), 0);
    chk("bp_row2_data", 1, 64'(wd[1][31:0]), 64'h2222_1111);

    // sop mid-frame, then early eop
    for (int n = 0; n < 6; n++) send(0, $urandom, n == 0, 1'b0);
    send(0, 32'h4444_3333, 1'b1, 1'b0);
    chk("sop_err", 0, 64'(err_sync[0]), 1);
    chk("sop_we", 0, 64'(ww[0]), 64'h3);
    chk("sop_addr", 0, 64'(wa[0]), 0);
    chk("sop_rows", 0, 64'(rows_written[0]), 0);
    for (int n = 1; n < 11; n++) send(0, $urandom, 1'b0, 1'b0);
    send(0, $urandom, 1'b0, 1'b1);
    chk("eop_err", 0, 64'(err_sync[0]), 1);
    chk("eop_we", 0, 64'(ww[0]), 64'h3);
    chk("eop_addr", 0, 64'(wa[0][29:0]), 64'({15'd7, 15'd7}));
    @(negedge clk);
    chk("eop_rows", 0, 64'(rows_written[0]), 3);
    chk("eop_no_done", 0, 64'(frame_done[0]), 0);
    send(0, $urandom, 1'b0, 1'b0);
    chk("idle_drop", 0, 64'(ww[0]), 0);
    chk("eop_done_count", 0, 64'(fd_count[0]), 1);

    // Reset in the middle of a row
    send(0, $urandom, 1'b1, 1'b0);
    send(0, $urandom, 1'b0, 1'b0);
    @(negedge clk);
    in_valid[0] = 1'b1; in_sop[0] = 1'b0; in_data[0] = $urandom;
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_ready", 0, 64'(in_ready[0]), 0);
    chk("rst_we", 0, 64'(ww[0]), 0);
    chk("rst_addr", 0, 64'(wa[0]), 0);
    chk("rst_rows", 0, 64'(rows_written[0]), 0);
    chk("rst_err", 0, 64'(err_sync[0]), 0);
    reset_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("post_rst_no_write", 0, 64'(ww[0]), 0);
    end
    in_valid[0] = 1'b0;
    send(0, $urandom, 1'b1, 1'b0);
    chk("restart_we", 0, 64'(ww[0]), 64'h3);

    // Randomized traffic on both instances
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset_n = ($urandom_range(0, 599) != 0);
      for (int i = 0; i < 2; i++) begin
        in_valid[i]   = ($urandom_range(0, 9) < 7);
        in_data[i]    = $urandom;
        in_sop[i]     = ($urandom_range(0, 29) == 0);
        in_eop[i]     = ($urandom_range(0, 49) == 0);
        rows_freed[i] = RW'($urandom_range(0, H));
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) in_valid[i] = 1'b0;
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
